// File: rtl/output_writeback_buffer.sv
// output_writeback_buffer: FIFO-buffered, strided writeback of aligned activation words to SRAM over req/gnt.
module output_writeback_buffer #(
  parameter int ACT_DATA_WIDTH = 8,
  parameter int N_DIM_ARRAY = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] addr_stride,
  input  logic [CNT_WIDTH-1:0] word_count,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] input_word,
  input  logic input_enable,
  output logic mem_req,
  input  logic mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] mem_wdata,
  output logic mem_we,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int W = N_DIM_ARRAY*ACT_DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW+1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] stride_q, addr_q;
  logic [CNT_WIDTH-1:0] count_q, accepted, written;
  logic full, push_req, push, pop;
  always_comb begin
    full = fifo_level == LW'(FIFO_DEPTH);
    push_req = state == RUN && input_enable && accepted < count_q;
    pop = mem_req && mem_gnt;
    push = push_req && (!full || pop);
  end
  assign mem_req = state == RUN && fifo_level != '0;
  assign mem_we = mem_req;
  assign mem_addr = addr_q;
  // gate the head so stale FIFO contents never leak onto the port when idle
  assign mem_wdata = mem_req ? mem[rd_ptr] : '0;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= input_word;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      addr_q <= '0;
      stride_q <= '0;
      count_q <= '0;
      accepted <= '0;
      written <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_q <= base_addr;
          stride_q <= addr_stride;
          count_q <= word_count;
          accepted <= '0;
          written <= '0;
          overflow <= 1'b0;
          state <= word_count != '0 ? RUN : DONE;
        end
        RUN: begin
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            accepted <= accepted + 1'b1;
          end
          if (push_req && !push) overflow <= 1'b1;
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            written <= written + 1'b1;
            addr_q <= addr_q + stride_q;
            if (written + 1'b1 == count_q) state <= DONE;
          end
          fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_writeback_buffer.sv
// tb_output_writeback_buffer: directed scoreboard bench for output_writeback_buffer.
module tb_output_writeback_buffer;
  logic clk = 1'b0;
  logic reset, start, input_enable, mem_gnt;
  logic [15:0] base_addr, addr_stride, word_count;
  logic [31:0] input_word;
  logic mem_req, mem_we, busy, done, overflow;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] fifo_level;
  typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  int checks = 0, errors = 0, nwrites = 0, done_seen = 0;
  logic [31:0] w [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};

  output_writeback_buffer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .addr_stride(addr_stride), .word_count(word_count), .input_word(input_word),
    .input_enable(input_enable), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy),
    .done(done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] b, input logic [15:0] s, input logic [15:0] c);
    base_addr = b; addr_stride = s; word_count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Writes happen on the edge after a cycle with req&gnt; compare against the scoreboard head.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (!reset && mem_req && mem_gnt) begin
      nwrites++;
      chk("we_eq_req", mem_we, 1'b1);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  initial begin
    int n0;
    reset = 1'b1; start = 1'b0; input_enable = 1'b0; mem_gnt = 1'b0;
    base_addr = '0; addr_stride = '0; word_count = '0; input_word = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    // streaming, one-cycle latency, gnt tied high
    mem_gnt = 1'b1;
    cfg(16'h0100, 16'd1, 16'd4);
    chk("stream_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      input_word = w[i]; input_enable = 1'b1;
      exp_q.push_back({16'h0100 + 16'(i), w[i]});
      tick();
      chk("stream_lat_req", mem_req, 1);
      chk("stream_lat_data", mem_wdata, w[i]);
    end
    input_enable = 1'b0;
    tick();
    chk("stream_done", done, 1);
    chk("stream_busy_off", busy, 0);
    chk("stream_ovf", overflow, 0);
    chk("stream_drained", exp_q.size(), 0);
    tick();
    chk("stream_done_once", done, 0);

    // backpressure and overflow
    mem_gnt = 1'b0;
    cfg(16'h0200, 16'd4, 16'd10);
    for (int i = 0; i < 12; i++) begin
      input_word = 32'hA000_0000 + 32'(i); input_enable = 1'b1;
      if (i < 8) exp_q.push_back({16'h0200 + 16'(4*i), 32'hA000_0000 + 32'(i)});
      tick();
    end
    chk("bp_level_sat", fifo_level, 8);
    chk("bp_ovf", overflow, 1);
    input_enable = 1'b0;
    n0 = nwrites;
    mem_gnt = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("bp_nwrites", nwrites - n0, 8);
    chk("bp_level_empty", fifo_level, 0);
    chk("bp_busy", busy, 1);
    chk("bp_no_done", done_seen, 1);
    chk("bp_ovf_sticky", overflow, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("bp_rst_ovf", overflow, 0);

    // full FIFO with simultaneous push and pop
    mem_gnt = 1'b0;
    cfg(16'h0300, 16'd1, 16'd9);
    for (int i = 0; i < 8; i++) begin
      input_word = 32'hB000_0000 + 32'(i); input_enable = 1'b1;
      exp_q.push_back({16'h0300 + 16'(i), 32'hB000_0000 + 32'(i)});
      tick();
    end
    chk("full_level", fifo_level, 8);
    input_word = 32'hB000_0008; mem_gnt = 1'b1;
    exp_q.push_back({16'h0308, 32'hB000_0008});
    tick();
    input_enable = 1'b0;
    chk("full_pp_level", fifo_level, 8);
    chk("full_pp_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("full_done", done, 1);
    chk("full_drained", exp_q.size(), 0);
    tick();

    // address wrap
    cfg(16'hFFFE, 16'd1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      input_word = w[3-i]; input_enable = 1'b1;
      exp_q.push_back({16'hFFFE + 16'(i), w[3-i]});
      tick();
    end
    input_enable = 1'b0;
    tick();
    chk("wrap_done", done, 1);
    chk("wrap_drained", exp_q.size(), 0);
    tick();

    // zero-length transfer
    cfg(16'h0500, 16'd1, 16'd0);
    chk("zero_done", done, 1);
    chk("zero_req", mem_req, 0);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_once", done, 0);

    // reset mid-transfer, then stray input in IDLE
    mem_gnt = 1'b0;
    cfg(16'h0400, 16'd1, 16'd8);
    for (int i = 0; i < 3; i++) begin
      input_word = 32'hC000_0000 + 32'(i); input_enable = 1'b1;
      tick();
    end
    input_enable = 1'b0;
    chk("mid_level", fifo_level, 3);
    chk("mid_req", mem_req, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_req", mem_req, 0);
    chk("abort_level", fifo_level, 0);
    chk("abort_busy", busy, 0);
    mem_gnt = 1'b1; input_enable = 1'b1; input_word = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) tick();
    input_enable = 1'b0;
    chk("idle_level", fifo_level, 0);
    chk("idle_req", mem_req, 0);
    chk("idle_ovf", overflow, 0);
    chk("total_done", done_seen, 4);
    chk("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_writeback_buffer.md
Name: output_writeback_buffer

Overview:
- Stage directly downstream of output alignment/padding; consumes its aligned, zero-padded activation words (data plus enable, no backpressure).
- Buffers words in a small FIFO and drains them to activation SRAM through a req/gnt write port.
- Generates strided write addresses from a base address and signals completion after a programmed word count.
- Decouples the array's output cadence from SRAM arbitration stalls.

Parameters:
ACT_DATA_WIDTH, 8, bits per activation element
N_DIM_ARRAY, 4, elements per word; word width W = N_DIM_ARRAY*ACT_DATA_WIDTH
FIFO_DEPTH, 8, FIFO entries (power of 2, >=2)
ADDR_WIDTH, 16, SRAM word-address width
CNT_WIDTH, 16, width of word counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches config, begins a transfer
base_addr  in  ADDR_WIDTH  first write address
addr_stride  in  ADDR_WIDTH  address increment per written word
word_count  in  CNT_WIDTH  number of words in the transfer
input_word  in  W  aligned activation word (signed elements)
input_enable  in  1  input_word valid this cycle
mem_req  out  1  write request
mem_gnt  in  1  SRAM accepts request this cycle
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  W  write data
mem_we  out  1  write enable (equals mem_req)
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at completion
overflow  out  1  sticky: a word was dropped because the FIFO was full
fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (synchronous, active-high) has priority over everything. It clears the FIFO and all counters. State goes to IDLE. All outputs are 0.
- Reset asserted mid-transfer aborts the transfer with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, mem_req=0.
  - input_enable is ignored; nothing is stored and no flags change.
  - On start: latch base_addr, addr_stride and word_count; clear accepted/written counters and overflow; address register <= base_addr.
  - Next state is RUN if word_count!=0, otherwise DONE.
- RUN:
  - busy=1.
  - Push: input_enable=1 and accepted<word_count writes input_word to the tail.
    - If the FIFO is full and no pop happens the same cycle, the word is dropped, overflow<=1, and accepted is not incremented.
    - Push while full with a simultaneous pop succeeds.
    - Pushes with accepted==word_count are ignored silently.
  - Pop: mem_req is asserted whenever the FIFO is non-empty. mem_wdata is the head entry and mem_addr is the address register.
    - On mem_req&&mem_gnt: pop, written++, and address register += addr_stride (modulo 2^ADDR_WIDTH wrap).
    - mem_req, mem_addr and mem_wdata hold stable while mem_gnt=0.
  - When a pop makes written==word_count, next state is DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - overflow stays set until the next start.
- start while in RUN or DONE is ignored.
- Latency: a word pushed in cycle t into an empty FIFO appears on mem_req/mem_wdata in cycle t+1. With mem_gnt tied high, throughput is 1 word/cycle.
- fifo_level: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Range 0..FIFO_DEPTH.
- Data is passed bit-exact. There is no arithmetic on the payload.

Test Plan:
- Streaming: base=0x0100, stride=1, count=4, words 0x11223344,0x55667788,0x99AABBCC,0xDDEEFF00 on consecutive cycles, gnt=1 -> writes at 0x0100..0x0103 with matching data, each one cycle after its push. done pulses one cycle after the 4th grant; overflow=0.
- Backpressure: count=10, stride=4, gnt=0 for the first 12 cycles while input_enable=1 every cycle -> fifo_level saturates at 8, overflow=1. After gnt=1, exactly 8 writes at base, base+4 ... base+28. No done; busy stays 1 until reset or the remaining words arrive and are written.
- Full with simultaneous push/pop: fill to 8, then gnt=1 and input_enable=1 in the same cycle -> level stays 8, overflow stays 0, and the new word is written 8 pops later.
- Address wrap: base=0xFFFE, stride=1, count=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- count=0: start -> done pulse the next cycle; mem_req never asserts.
- Reset and stray inputs: reset mid-RUN with 3 words buffered -> next cycle mem_req=0, fifo_level=0, busy=0, no done. input_enable in IDLE -> fifo_level stays 0.
